// File: rtl/apb_cmd_master.sv
// -----------------------------------------------------------------------------
// apb_cmd_master
//
// Converts a simple valid/ready command stream into single APB transfers and
// returns one response per command. Exactly one transfer is in flight at a
// time: a command is only taken in IDLE, and the next one is not taken until
// the response has been handed off.
//
// Ports
//   PCLK, PRESETn        clock, asynchronous active-low reset
//   cmd_valid/cmd_ready  command handshake (cmd_ready high only in IDLE)
//   cmd_write            1 = write, 0 = read
//   cmd_addr, cmd_wdata  target address and write data
//   rsp_valid/rsp_ready  response handshake
//   rsp_rdata            read data (0 for writes and for timeouts)
//   rsp_err              PSLVERR from the slave, or access timeout
//   PSEL, PENABLE, PWRITE, PADDR, PWDATA   APB requester outputs
//   PRDATA, PREADY, PSLVERR                APB completer inputs
//
// Parameters
//   ADDR_WIDTH, DATA_WIDTH  APB bus widths
//   TIMEOUT                 ACCESS cycles without PREADY before the transfer
//                           is abandoned with an error; 0 waits forever
// -----------------------------------------------------------------------------
module apb_cmd_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,

    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,

    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    // Counter is wide enough to hold TIMEOUT itself (and is at least 1 bit
    // when the timeout is disabled).
    localparam int CNT_W = $clog2(TIMEOUT + 2);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t                  state_reg, state_next;
    logic                    cmd_write_reg, cmd_write_next;
    logic [ADDR_WIDTH-1:0]   cmd_addr_reg, cmd_addr_next;
    logic [DATA_WIDTH-1:0]   cmd_wdata_reg, cmd_wdata_next;
    logic [DATA_WIDTH-1:0]   rsp_rdata_reg, rsp_rdata_next;
    logic                    rsp_err_reg, rsp_err_next;
    logic [CNT_W-1:0]        timeout_cnt_reg, timeout_cnt_next;
    logic [CNT_W-1:0]        timeout_cnt_inc;

    assign timeout_cnt_inc = timeout_cnt_reg + CNT_W'(1);

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_reg       <= IDLE;
            cmd_write_reg   <= 1'b0;
            cmd_addr_reg    <= '0;
            cmd_wdata_reg   <= '0;
            rsp_rdata_reg   <= '0;
            rsp_err_reg     <= 1'b0;
            timeout_cnt_reg <= '0;
        end else begin
            state_reg       <= state_next;
            cmd_write_reg   <= cmd_write_next;
            cmd_addr_reg    <= cmd_addr_next;
            cmd_wdata_reg   <= cmd_wdata_next;
            rsp_rdata_reg   <= rsp_rdata_next;
            rsp_err_reg     <= rsp_err_next;
            timeout_cnt_reg <= timeout_cnt_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next       = state_reg;
        cmd_write_next   = cmd_write_reg;
        cmd_addr_next    = cmd_addr_reg;
        cmd_wdata_next   = cmd_wdata_reg;
        rsp_rdata_next   = rsp_rdata_reg;
        rsp_err_next     = rsp_err_reg;
        timeout_cnt_next = timeout_cnt_reg;

        case (state_reg)
            IDLE: begin
                // cmd_ready is high throughout IDLE, so cmd_valid alone
                // completes the handshake.
                if (cmd_valid) begin
                    cmd_write_next = cmd_write;
                    cmd_addr_next  = cmd_addr;
                    cmd_wdata_next = cmd_wdata;
                    state_next     = SETUP;
                end
            end

            SETUP: begin
                timeout_cnt_next = '0;
                state_next       = ACCESS;
            end

            ACCESS: begin
                if (PREADY) begin
                    // PREADY takes priority over a timeout expiring on the
                    // same cycle, so a late but valid completion is kept.
                    rsp_rdata_next = cmd_write_reg ? '0 : PRDATA;
                    rsp_err_next   = PSLVERR;
                    state_next     = RESP;
                end else if (TIMEOUT != 0) begin
                    timeout_cnt_next = timeout_cnt_inc;
                    if (timeout_cnt_inc == TIMEOUT_CNT) begin
                        rsp_rdata_next = '0;
                        rsp_err_next   = 1'b1;
                        state_next     = RESP;
                    end
                end
            end

            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs: decoded from state so reset clears them immediately.
    // The bus fields are zeroed whenever PSEL is low to keep idle bus quiet.
    // -------------------------------------------------------------------------
    logic bus_active;
    assign bus_active = (state_reg == SETUP) || (state_reg == ACCESS);

    assign cmd_ready = (state_reg == IDLE);
    assign rsp_valid = (state_reg == RESP);
    assign rsp_rdata = rsp_rdata_reg;
    assign rsp_err   = rsp_err_reg;

    assign PSEL      = bus_active;
    assign PENABLE   = (state_reg == ACCESS);
    assign PWRITE    = bus_active ? cmd_write_reg : 1'b0;
    assign PADDR     = bus_active ? cmd_addr_reg  : '0;
    assign PWDATA    = bus_active ? cmd_wdata_reg : '0;

endmodule

// File: doc/apb_cmd_master.md
APB_CMD_MASTER -- requirements
Module: apb_cmd_master

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, APB address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, APB data width.
REQ-003 SHALL have parameter TIMEOUT, default 255, maximum ACCESS cycles without PREADY; 0 disables the timeout.
REQ-004 SHALL have port PCLK  input  1  the single clock.
REQ-005 SHALL have port PRESETn  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port cmd_valid  input  1  command offered.
REQ-007 SHALL have port cmd_ready  output  1  command accepted when high with cmd_valid.
REQ-008 SHALL have port cmd_write  input  1  1=write, 0=read.
REQ-009 SHALL have port cmd_addr  input  ADDR_WIDTH  target address.
REQ-010 SHALL have port cmd_wdata  input  DATA_WIDTH  write data.
REQ-011 SHALL have port rsp_valid  output  1  response available.
REQ-012 SHALL have port rsp_ready  input  1  response consumed when high with rsp_valid.
REQ-013 SHALL have port rsp_rdata  output  DATA_WIDTH  read data; 0 for writes and on timeout.
REQ-014 SHALL have port rsp_err  output  1  PSLVERR or timeout.
REQ-015 SHALL have ports PSEL, PENABLE, PWRITE  output  1 each; PADDR  output  ADDR_WIDTH; PWDATA  output  DATA_WIDTH.
REQ-016 SHALL have ports PRDATA  input  DATA_WIDTH; PREADY, PSLVERR  input  1 each.

Function
REQ-017 SHALL implement FSM states IDLE, SETUP, ACCESS, RESP.
REQ-018 cmd_ready SHALL be 1 only in IDLE; no other buffering (one outstanding transfer).
REQ-019 IDLE: on cmd_valid&&cmd_ready, register cmd_write/cmd_addr/cmd_wdata and go to SETUP next cycle.
REQ-020 SETUP: PSEL=1, PENABLE=0, PADDR/PWRITE/PWDATA = registered command; always go to ACCESS next cycle.
REQ-021 ACCESS: PSEL=1, PENABLE=1, address/control/data unchanged from SETUP; stay while PREADY=0.
REQ-022 ACCESS with PREADY=1: capture PRDATA (reads only, else 0) into rsp_rdata and PSLVERR into rsp_err; go to RESP; minimum command-to-rsp_valid latency 3 cycles.
REQ-023 Timeout: counter cleared on SETUP, increments each ACCESS cycle with PREADY=0; when it reaches TIMEOUT (TIMEOUT!=0), go to RESP with rsp_err=1, rsp_rdata=0, PSEL/PENABLE dropped next cycle.
REQ-024 PREADY=1 on the same cycle the counter reaches TIMEOUT SHALL complete normally (PREADY wins).
REQ-025 RESP: rsp_valid=1, PSEL=PENABLE=0; rsp_rdata/rsp_err stable until rsp_valid&&rsp_ready, then go to IDLE (cmd_ready=1 the following cycle).
REQ-026 In IDLE and RESP, PADDR, PWDATA, PWRITE SHALL be 0.
REQ-027 cmd_* inputs SHALL be ignored outside IDLE.

Reset
REQ-028 PRESETn low SHALL immediately force state IDLE and drive PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err, timeout counter to 0; cmd_ready to 1 (combinational from state).
REQ-029 Reset asserted during SETUP/ACCESS/RESP SHALL abandon the transfer with no response produced.

Verification
REQ-030 Write addr=0x10, wdata=0xA5A5_0001, PREADY tied 1 -> SETUP cycle then one ACCESS cycle with PADDR=0x10, PWRITE=1; rsp_valid 3 cycles after accept, rsp_err=0, rsp_rdata=0.
REQ-031 Read addr=0x04, PREADY low 3 ACCESS cycles then high with PRDATA=0x1234_5678 -> 4 ACCESS cycles, rsp_rdata=0x1234_5678, rsp_err=0.
REQ-032 Read with PSLVERR=1 at PREADY -> rsp_err=1, rsp_rdata=PRDATA value captured.
REQ-033 TIMEOUT=4, PREADY held 0 -> exactly 4 ACCESS cycles, then rsp_valid=1, rsp_err=1, rsp_rdata=0, PSEL=0.
REQ-034 rsp_ready held 0 for 5 cycles with cmd_valid high -> cmd_ready stays 0, response stable, no new SETUP until handshake.
REQ-035 PRESETn pulsed low during ACCESS -> PSEL/PENABLE/rsp_valid 0 immediately, cmd_ready 1, no response after release.
